// File: rtl/chip8_exec_sched_pkg.sv
// chip8_exec_sched_pkg: scheduler state encoding and hex-display status word layout
package chip8_exec_sched_pkg;
   typedef enum logic [1:0] {
      HALT     = 2'd0,
      ISSUE    = 2'd1,
      WAIT     = 2'd2,
      THROTTLE = 2'd3
   } sched_state_t;
   localparam int ST_STATE_LSB = 14;
   localparam int ST_FAULT     = 13;
   localparam int ST_BP_HIT    = 12;
   localparam int ST_PC_MSB    = 11;
endpackage

// File: rtl/sched_tick_gen.sv
// sched_tick_gen: frame counter 0..TICK_DIV-1 emitting a one-cycle wrap strobe (not a clock)
module sched_tick_gen #(
   parameter int TICK_DIV = 1666667
) (
   input  logic clk,
   input  logic rst,
   output logic wrap
);
   localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [CW-1:0] cnt;
   assign wrap = cnt == CW'(TICK_DIV - 1);
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= wrap ? '0 : cnt + CW'(1);
   end
endmodule

// File: rtl/chip8_exec_sched.sv
// chip8_exec_sched: issues/throttles Chip-8 instructions, 60 Hz timer tick, run/step, retire timeout.
// Define CHIP8_SCHED_BP_EN to enable the PC breakpoint (bp_addr/bp_arm/bp_hit).
module chip8_exec_sched
   import chip8_exec_sched_pkg::*;
#(
   parameter int TICK_DIV        = 1666667,
   parameter int INSTR_PER_FRAME = 10,
   parameter int DONE_TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        step,
   output logic        cpu_go,
   input  logic        cpu_done,
   input  logic [11:0] cpu_pc,
   output logic        timer_tick,
   output logic        halted,
   output logic        fault,
   output logic [15:0] status,
   input  logic [11:0] bp_addr,
   input  logic        bp_arm,
   output logic        bp_hit
);
   localparam int TW = $clog2(DONE_TIMEOUT + 1);
   sched_state_t  state, state_nx;
   logic          wrap, step_q, step_edge, single, retired, retire, timeout, bp_pend, issue;
   logic [7:0]    budget;
   logic [TW-1:0] tcnt;
   logic [11:0]   last_pc;

   sched_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk (clk),
      .rst (rst),
      .wrap(wrap)
   );

   // A retire is registered first and acted on the following cycle, so a new go never
   // lands directly after cpu_done.
   always_comb begin
      issue     = state == ISSUE;
      step_edge = step & ~step_q;
      retire    = state == WAIT && !retired && cpu_done;
      timeout   = state == WAIT && !retired && !cpu_done && tcnt == TW'(DONE_TIMEOUT - 1);
      state_nx  = state;
      case (state)
         HALT:     state_nx = (!fault && (run || step_edge)) ? ISSUE : HALT;
         ISSUE:    state_nx = WAIT;
         WAIT:     state_nx = timeout ? HALT
                            : !retired ? WAIT
                            : (single || bp_pend || !run) ? HALT
                            : budget >= 8'(INSTR_PER_FRAME) ? THROTTLE : ISSUE;
         THROTTLE: state_nx = wrap ? (run ? ISSUE : HALT) : (run ? THROTTLE : HALT);
         default:  state_nx = HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HALT;
         cpu_go     <= 1'b0;
         halted     <= 1'b1;
         timer_tick <= 1'b0;
         fault      <= 1'b0;
         step_q     <= 1'b0;
         single     <= 1'b0;
         retired    <= 1'b0;
         budget     <= '0;
         tcnt       <= '0;
         last_pc    <= '0;
      end else begin
         state      <= state_nx;
         cpu_go     <= state_nx == ISSUE;
         halted     <= state_nx == HALT;
         timer_tick <= wrap & run & ~fault;
         step_q     <= step;
         budget     <= (wrap ? 8'd0 : budget) + {7'd0, issue};
         tcnt       <= state == WAIT ? tcnt + TW'(1) : '0;
         retired    <= retire;
         if (timeout) fault <= 1'b1;
         if (state == HALT && state_nx == ISSUE) single <= !run;
         if (retire) last_pc <= cpu_pc;
      end
   end

`ifdef CHIP8_SCHED_BP_EN
   logic bp_match;
   assign bp_match = bp_arm && cpu_pc == bp_addr;
   always_ff @(posedge clk) begin
      if (rst) begin
         bp_pend <= 1'b0;
         bp_hit  <= 1'b0;
      end else if (retire) begin
         bp_pend <= bp_match;
         if (bp_match) bp_hit <= 1'b1;
      end
   end
`else
   logic bp_unused;
   assign bp_unused = ^{bp_addr, bp_arm};
   assign bp_pend   = 1'b0;
   assign bp_hit    = 1'b0;
`endif

   always_comb begin
      status                    = '0;
      status[ST_STATE_LSB +: 2] = state;
      status[ST_FAULT]          = fault;
      status[ST_BP_HIT]         = bp_hit;
      status[ST_PC_MSB:0]       = last_pc;
   end
endmodule

// File: tb/tb_chip8_exec_sched.sv
// tb_chip8_exec_sched: vector table plus hand sequences; CPU model retires 2 cycles after go,
// retired PCs are scoreboarded against status[11:0].
module tb_chip8_exec_sched;
   localparam int TD = 100, IPF = 3, DT = 8;
`ifdef CHIP8_SCHED_BP_EN
   localparam int BPEXP = 1;
`else
   localparam int BPEXP = 0;
`endif
   logic        clk = 1'b0, rst = 1'b1, run = 1'b0, step = 1'b0, cpu_done = 1'b0, bp_arm = 1'b0;
   logic [11:0] cpu_pc = '0, bp_addr = '0, pc_ctr = '0;
   logic        cpu_go, timer_tick, halted, fault, bp_hit;
   logic [15:0] status;
   int          n_cmp = 0, n_bad = 0, cyc = 0, go_cnt = 0, tick_cnt = 0, dly = 0;
   bit          hold = 0;
   logic [11:0] exp_q[$];

   typedef struct {
      logic        run;
      logic        step;
      int          ncyc;
      logic [11:0] pc;
      int          exp_go;
      int          exp_tick;
      logic        exp_halted;
      logic [11:0] exp_pc;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   chip8_exec_sched #(.TICK_DIV(TD), .INSTR_PER_FRAME(IPF), .DONE_TIMEOUT(DT)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .cpu_go(cpu_go), .cpu_done(cpu_done),
      .cpu_pc(cpu_pc), .timer_tick(timer_tick), .halted(halted), .fault(fault),
      .status(status), .bp_addr(bp_addr), .bp_arm(bp_arm), .bp_hit(bp_hit)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock: sample after the edge, then run the CPU model and scoreboard.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (cpu_go) go_cnt++;
      if (timer_tick) tick_cnt++;
      if (cpu_done && exp_q.size() > 0) chk("last_pc_sb", int'(status[11:0]), int'(exp_q.pop_front()));
      cpu_done = 1'b0;
      if (dly > 0) begin
         dly--;
         if (dly == 0 && !hold) begin
            cpu_done = 1'b1;
            cpu_pc   = pc_ctr;
            exp_q.push_back(pc_ctr);
            pc_ctr   = pc_ctr + 12'd2;
         end
      end
      if (cpu_go) dly = 2;
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; step = 1'b0; hold = 0; dly = 0; cpu_done = 1'b0; bp_arm = 1'b0;
      exp_q.delete();
      repeat (3) tick();
      chk("rst_halted", halted, 1);
      chk("rst_go", cpu_go, 0);
      chk("rst_status", status, 0);
      chk("rst_tick", timer_tick, 0);
      chk("rst_fault", fault, 0);
      chk("rst_bp_hit", bp_hit, 0);
      rst = 1'b0;
   endtask

   task automatic wait_go(input int lim, output int at);
      at = -1;
      for (int i = 0; i < lim && at < 0; i++) begin
         tick();
         if (cpu_go) at = cyc;
      end
      chk("go_seen", at >= 0, 1);
   endtask

   initial begin
      int g0, t0, g, f, d, saw, win_go, started, last_t;
      vecs[0] = '{1'b0, 1'b0, 120, 12'h204, 0, 0, 1'b1, 12'h000};
      vecs[1] = '{1'b0, 1'b1, 10,  12'h204, 1, 0, 1'b1, 12'h204};
      vecs[2] = '{1'b0, 1'b1, 10,  12'h300, 0, 0, 1'b1, 12'h204};
      vecs[3] = '{1'b0, 1'b0, 5,   12'h300, 0, 0, 1'b1, 12'h204};
      vecs[4] = '{1'b0, 1'b1, 10,  12'h206, 1, 0, 1'b1, 12'h206};

      // reset, idle, single-step
      do_reset();
      tick();
      chk("post_rst_halted", halted, 1);
      chk("post_rst_go", cpu_go, 0);
      chk("post_rst_status", status, 0);
      for (int i = 0; i < 5; i++) begin
         run = vecs[i].run; step = vecs[i].step; pc_ctr = vecs[i].pc;
         g0 = go_cnt; t0 = tick_cnt;
         repeat (vecs[i].ncyc) tick();
         chk($sformatf("vec%0d_go", i), go_cnt - g0, vecs[i].exp_go);
         chk($sformatf("vec%0d_tick", i), tick_cnt - t0, vecs[i].exp_tick);
         chk($sformatf("vec%0d_halted", i), halted, int'(vecs[i].exp_halted));
         chk($sformatf("vec%0d_pc", i), int'(status[11:0]), int'(vecs[i].exp_pc));
      end

      // free run: 3 go per frame, ticks 100 apart, THROTTLE reached
      do_reset();
      run = 1'b1; pc_ctr = 12'h200;
      saw = 0; win_go = 0; started = 0; last_t = -1; t0 = tick_cnt;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 0) chk("run_latency", cpu_go, 1);
         if (timer_tick) begin
            if (started) chk("frame_go_count", win_go, IPF);
            else chk("first_frame_go", win_go, IPF);
            if (last_t >= 0) chk("tick_spacing", cyc - last_t, TD);
            started = 1; win_go = 0; last_t = cyc;
         end
         if (cpu_go) win_go++;
         if (status[15:14] == 2'd3) saw = 1;
      end
      chk("tick_count_2_3", (tick_cnt - t0 >= 2) && (tick_cnt - t0 <= 3), 1);
      chk("throttle_seen", saw, 1);

      // retire timeout -> sticky fault, everything ignored
      do_reset();
      hold = 1; run = 1'b1;
      wait_go(10, g);
      f = -1;
      for (int i = 0; i < 20 && f < 0; i++) begin
         tick();
         if (fault) f = cyc;
      end
      chk("fault_latency", f - g, 9);
      chk("fault_halted", halted, 1);
      chk("fault_status", status[15:13], 3'b001);
      g0 = go_cnt; t0 = tick_cnt;
      for (int i = 0; i < 40; i++) begin
         run  = i < 20;
         step = (i % 4) >= 2;
         tick();
      end
      chk("fault_no_go", go_cnt - g0, 0);
      chk("fault_sticky", fault, 1);
      chk("fault_still_halted", halted, 1);

      // run dropped right after go: instruction completes, then HALT
      do_reset();
      run = 1'b1; pc_ctr = 12'h2F0;
      wait_go(10, g);
      tick();
      run = 1'b0;
      g0 = go_cnt;
      repeat (12) tick();
      chk("drop_no_go", go_cnt - g0, 0);
      chk("drop_halted", halted, 1);
      chk("drop_pc", int'(status[11:0]), 12'h2F0);

      // breakpoint at 0x20A
      do_reset();
      bp_arm = 1'b1; bp_addr = 12'h20A; pc_ctr = 12'h202; run = 1'b1;
      d = -1; saw = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (d >= 0 && cyc > d && cyc <= d + 4 && halted) saw = 1;
         if (cpu_done && cpu_pc == 12'h20A) d = cyc;
         if (d >= 0 && cyc > d + 4 && status[11:0] == 12'h20C) break;
      end
      chk("bp_retire_seen", d >= 0, 1);
      chk("bp_halt", saw, BPEXP);
      chk("bp_hit", bp_hit, BPEXP);
      chk("bp_status_bit", status[12], BPEXP);
      chk("bp_resume_20C", int'(status[11:0]), 12'h20C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
